// File: rtl/tc_clk_div_prog.sv
`timescale 1ns/1ps
// tc_clk_div_prog: programmable integer clock divider with glitch-free run-time divisor updates.
// Latency: an accepted divisor takes effect at the end of the current divided period (<= old N + 1 cycles).
// Backpressure: div_ready_o is low while an update is pending; div_valid_i is ignored until it is applied.
// Option: define TC_CLK_DIV_ODD_HALF_DUTY_EN for 50% duty on odd divisors (adds one negedge flop).
module tc_clk_div_prog #(
  parameter int unsigned DivWidth   = 8,
  parameter int unsigned DefaultDiv = 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                test_mode_i,
  input  logic                en_i,
  input  logic [DivWidth-1:0] div_i,
  input  logic                div_valid_i,
  output logic                div_ready_o,
  output logic                clk_o
);

  localparam logic [DivWidth-1:0] DefDiv = DivWidth'(DefaultDiv);

  logic [DivWidth-1:0] div_q;
  logic [DivWidth-1:0] cnt_q;
  logic [DivWidth-1:0] cnt_next;
  logic [DivWidth-1:0] pend_div_q;
  logic [DivWidth-1:0] half;
  logic [DivWidth-1:0] half_new;
  logic                pend_q;
  logic                clk_div_q;
  logic                run_q;
  logic                div_mode;
  logic                at_end;
  logic                xfer;
  logic                apply;
  logic                clk_div;
  logic                mux_sel;
  logic                clk_mux;
  logic                en_latch;

  assign half        = div_q >> 1;
  assign half_new    = pend_div_q >> 1;
  assign div_mode    = (div_q > DivWidth'(1));
  // run_q marks that the first edge after reset has passed; that edge starts a period at count 0.
  assign at_end      = run_q && (cnt_q == (div_q - DivWidth'(1)));
  assign div_ready_o = !pend_q;
  assign xfer        = div_valid_i && !pend_q;
  // BYPASS has no period to finish, so a pending value is taken on the very next edge.
  assign apply       = pend_q && (!div_mode || at_end);

  // Next count: wraps at N-1, held at 0 in BYPASS and before the first post-reset edge.
  always_comb begin
    cnt_next = '0;
    if (div_mode && run_q && !at_end) begin
      cnt_next = cnt_q + DivWidth'(1);
    end
  end

  // Divisor, counter, handshake and divided-clock registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      div_q      <= DefDiv;
      cnt_q      <= '0;
      pend_q     <= 1'b0;
      pend_div_q <= '0;
      clk_div_q  <= 1'b0;
      run_q      <= 1'b0;
    end else begin
      run_q <= 1'b1;
      if (xfer) begin
        pend_q     <= 1'b1;
        pend_div_q <= div_i;
      end
      if (apply) begin
        div_q     <= pend_div_q;
        cnt_q     <= '0;
        pend_q    <= 1'b0;
        clk_div_q <= (half_new != '0);
      end else begin
        cnt_q     <= cnt_next;
        clk_div_q <= div_mode && (cnt_next < half);
      end
    end
  end

`ifdef TC_CLK_DIV_ODD_HALF_DUTY_EN
  logic clk_div_nq;

  // Half-cycle extension of the high phase, only meaningful for odd divisors.
  always_ff @(negedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      clk_div_nq <= 1'b0;
    end else begin
      clk_div_nq <= div_q[0] & clk_div_q;
    end
  end

  assign clk_div = clk_div_q | clk_div_nq;
`else
  assign clk_div = clk_div_q;
`endif

  // Clock mux (tc_clk_mux2 function): select follows div_q, which only changes at a period
  // boundary where both inputs rise together, so switching never produces a runt pulse.
  assign mux_sel = div_mode & ~test_mode_i;
  assign clk_mux = mux_sel ? clk_div : clk_i;

  // Clock gate (tc_clk_gating function): enable latched while the muxed clock is low.
  always_latch begin
    if (!clk_mux) begin
      en_latch <= en_i;
    end
  end

  // Test mode overrides the gate combinationally.
  assign clk_o = clk_mux & (en_latch | test_mode_i);

endmodule

// File: tb/tb_tc_clk_div_prog.sv
`timescale 1ns/1ps
// tb_tc_clk_div_prog: directed stimulus, queue-based period model and per-half-cycle compare.
// Latency: divided clock sampled 3 ns after each posedge and 3 ns after each negedge.
// Backpressure: div_valid held one cycle per update; ready checked against the model every sample.
module tb_tc_clk_div_prog;

  localparam int DefDiv = 4;

`ifdef TC_CLK_DIV_ODD_HALF_DUTY_EN
  localparam logic [6:0]  Div3Hi = 7'b0110110;
  localparam logic [10:0] ModeHi = 11'b11111110011;
`else
  localparam logic [6:0]  Div3Hi = 7'b0100100;
  localparam logic [10:0] ModeHi = 11'b11111100011;
`endif
  localparam logic [5:0]  Div3Lo = 6'b010010;
  localparam logic [10:0] ModeLo = 11'b00000110000;

  logic       clk_i = 1'b0;
  logic       rst = 1'b1;
  logic       tm = 1'b0;
  logic       en = 1'b1;
  logic [7:0] div_d = 8'd0;
  logic       dv = 1'b0;
  logic       div_ready;
  logic       clk_o;

  int total = 0;
  int bad = 0;

  tc_clk_div_prog #(.DivWidth(8), .DefaultDiv(DefDiv)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst),
    .test_mode_i (tm),
    .en_i        (en),
    .div_i       (div_d),
    .div_valid_i (dv),
    .div_ready_o (div_ready),
    .clk_o       (clk_o)
  );

  always #5 clk_i = ~clk_i;

  // ---------------- behavioural model ----------------
  // The remaining high/low levels of the current divided period sit in a queue;
  // an empty queue means the period just ended, which is where updates land.
  int  div_m = DefDiv;
  int  pdiv_m = 0;
  bit  pend_m = 1'b0;
  bit  v_m = 1'b0;
  bit  nq_m = 1'b0;
  bit  en_l_m = 1'b0;
  bit  xfer_m;
  bit  q[$];

  always @(posedge clk_i or posedge rst) begin
    if (rst) begin
      div_m  = DefDiv;
      pend_m = 1'b0;
      v_m    = 1'b0;
      q.delete();
    end else begin
      xfer_m = dv && !pend_m;
      if (pend_m && (div_m < 2 || q.size() == 0)) begin
        div_m  = pdiv_m;
        pend_m = 1'b0;
        q.delete();
      end
      if (xfer_m) begin
        pend_m = 1'b1;
        pdiv_m = int'(div_d);
      end
      if (div_m >= 2) begin
        if (q.size() == 0) begin
          for (int i = 0; i < div_m; i++) q.push_back(i < div_m / 2);
        end
        v_m = q.pop_front();
      end else begin
        v_m = 1'b0;
        q.delete();
      end
    end
  end

  always @(negedge clk_i or posedge rst) begin
    if (rst) nq_m = 1'b0;
    else     nq_m = (div_m % 2 == 1) ? v_m : 1'b0;
  end

  // ---------------- checking ----------------
  logic [63:0] dut_hi = '0, dut_lo = '0, mdl_hi = '0, mdl_lo = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, exp);
    end
  endtask

  task automatic sample(input bit ph);
    bit divd, mux, exp_clk;
    divd = v_m;
`ifdef TC_CLK_DIV_ODD_HALF_DUTY_EN
    divd = v_m | nq_m;
`endif
    mux     = (tm || div_m < 2) ? ph : divd;
    exp_clk = mux & (en_l_m | tm);
    if (!mux) en_l_m = en;
    chk(ph ? "clk_o_hi" : "clk_o_lo", clk_o, exp_clk);
    chk("div_ready", div_ready, !pend_m);
    if (ph) begin
      dut_hi = {dut_hi[62:0], clk_o};
      mdl_hi = {mdl_hi[62:0], exp_clk};
    end else begin
      dut_lo = {dut_lo[62:0], clk_o};
      mdl_lo = {mdl_lo[62:0], exp_clk};
    end
  endtask

  initial begin
    forever begin
      @(posedge clk_i);
      #3 sample(1'b1);
      #5 sample(1'b0);
    end
  end

  task automatic clear_hist();
    dut_hi = '0; dut_lo = '0; mdl_hi = '0; mdl_lo = '0;
  endtask

  // Minimum pulse width monitor for the mode-switch window.
  bit  mon_on = 1'b0;
  int  glitches = 0;
  time last_edge = 0;
  always @(clk_o) begin
    if (mon_on && (($time - last_edge) < 5)) glitches++;
    last_edge = $time;
  end

  task automatic sync(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    // Reset with DefaultDiv=4: clk_o low, ready high.
    sync(1);
    chk("rst_ready", div_ready, 1'b1);
    chk("rst_clk_o", clk_o, 1'b0);
    sync(2);
    rst = 1'b0;
    clear_hist();
    sync(8);
    #3;
    chk("div4_dut", dut_hi[7:0], 8'b11001100);
    chk("div4_mdl", mdl_hi[7:0], 8'b11001100);
    clear_hist();

    // Load 6 at count 1 of a div-4 period.
    sync(2);
    dv = 1'b1; div_d = 8'd6;
    sync(1);
    dv = 1'b0;
    chk("ld6_ready_lo0", div_ready, 1'b0);
    sync(1);
    chk("ld6_ready_lo1", div_ready, 1'b0);
    sync(1);
    chk("ld6_ready_hi", div_ready, 1'b1);
    sync(7);
    #3;
    chk("div6_dut", dut_hi[11:0], 12'b110011100011);
    chk("div6_mdl", mdl_hi[11:0], 12'b110011100011);

    // Divide by 3.
    dv = 1'b1; div_d = 8'd3;
    sync(1);
    dv = 1'b0;
    sync(3);
    clear_hist();
    sync(6);
    #3;
    chk("div3_hi_dut", dut_hi[6:0], Div3Hi);
    chk("div3_hi_mdl", mdl_hi[6:0], Div3Hi);
    chk("div3_lo_dut", dut_lo[5:0], Div3Lo);

    // BYPASS -> DIVIDE(5) -> BYPASS.
    dv = 1'b1; div_d = 8'd1;
    sync(1);
    dv = 1'b0;
    sync(2);
    #3;
    clear_hist();
    glitches = 0;
    mon_on = 1'b1;
    sync(3);
    dv = 1'b1; div_d = 8'd5;
    sync(1);
    dv = 1'b0;
    sync(3);
    dv = 1'b1; div_d = 8'd0;
    sync(1);
    dv = 1'b0;
    sync(3);
    #3;
    mon_on = 1'b0;
    chk("mode_hi_dut", dut_hi[10:0], ModeHi);
    chk("mode_hi_mdl", mdl_hi[10:0], ModeHi);
    chk("mode_lo_dut", dut_lo[10:0], ModeLo);
    chk("mode_glitch", glitches, 0);

    // en_i low for 10 cycles at div 4.
    dv = 1'b1; div_d = 8'd4;
    sync(1);
    dv = 1'b0;
    sync(3);
    en = 1'b0;
    #3;
    clear_hist();
    sync(10);
    #3;
    chk("en_off_hi", dut_hi[9:0], 10'd0);
    chk("en_off_lo", dut_lo[9:0], 10'd0);
    en = 1'b1;

    // Test mode: clk_o follows clk_i with en_i low.
    sync(1);
    tm = 1'b1; en = 1'b0;
    #2;
    chk("tm_hi", clk_o, 1'b1);
    #5;
    chk("tm_lo", clk_o, 1'b0);
    sync(3);
    en = 1'b1;
    sync(2);
    tm = 1'b0;

    // Reset mid-period with an update pending.
    sync(1);
    dv = 1'b1; div_d = 8'd7;
    sync(1);
    dv = 1'b0;
    chk("pend_ready", div_ready, 1'b0);
    sync(1);
    #3;
    rst = 1'b1;
    #2;
    chk("rst2_ready", div_ready, 1'b1);
    chk("rst2_clk_o", clk_o, 1'b0);
    sync(1);
    rst = 1'b0;
    clear_hist();
    sync(8);
    #3;
    chk("rst2_div4_dut", dut_hi[8:0], 9'b011001100);
    chk("rst2_div4_mdl", mdl_hi[8:0], 9'b011001100);

    sync(4);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
